// File: rtl/rvga_decode_pipe_if.sv
// rvga_decode_pipe_if: fetch-side and register-file-side handshake bundle of the decode stage
interface rvga_decode_pipe_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_pc, out_imm;
    logic [31:0]     out_inst;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [3:0]      out_aluop;
    logic [2:0]      out_brop, out_mdop;
    logic [1:0]      out_dwidth;
    logic [10:0]     out_ctrl;
    logic            out_illegal;
    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rd, out_rs1, out_rs2, out_imm,
               out_aluop, out_brop, out_mdop, out_dwidth, out_ctrl, out_illegal
    );
    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rd, out_rs1, out_rs2, out_imm,
               out_aluop, out_brop, out_mdop, out_dwidth, out_ctrl, out_illegal
    );
endinterface

// File: rtl/rvga_decode_pipe.sv
// rvga_decode_pipe: RV32I(+M) combinational decode feeding a valid/ready FIFO of pre-decoded entries
module rvga_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter bit EN_M  = 1'b0
) (
    input logic clk,
    input logic rst_n,
    rvga_decode_pipe_if.slave bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [3:0]      aluop;
        logic [2:0]      brop;
        logic [2:0]      mdop;
        logic [1:0]      dwidth;
        logic [10:0]     ctrl;
        logic            illegal;
    } entry_t;
    entry_t dec, head;
    entry_t mem [DEPTH];
    logic [31:0] inst;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ill, push, pop;
    logic [PW-1:0] rp, wp;
    logic [CW-1:0] cnt;
    assign inst = bus.in_inst;
    assign op = inst[6:0];
    assign f3 = inst[14:12];
    assign f7 = inst[31:25];
    function automatic logic [3:0] alu_of(input logic [2:0] f);
        return f == 3'd0 ? 4'd0 : f == 3'd6 ? 4'd8 : f == 3'd7 ? 4'd9 : {1'b0, f} + 4'd1;
    endfunction
    // ctrl bits: 0 rf_load 1 br 2 jal 3 jalr 4 mem_rd 5 mem_wr 6 mem_uns 7 rs1_pc 8 rs2_imm 9 rs2_word 10 md
    always_comb begin
        dec = '0;
        ill = 1'b0;
        dec.pc = bus.in_pc;
        dec.inst = inst;
        dec.imm = {{20{inst[31]}}, inst[31:20]};
        case (op)
            7'h37: begin dec.imm = {inst[31:12], 12'b0}; dec.aluop = 4'd10; dec.ctrl = 11'h101; end
            7'h17: begin dec.imm = {inst[31:12], 12'b0}; dec.ctrl = 11'h181; end
            7'h6f: begin dec.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0}; dec.ctrl = 11'h285; end
            7'h67: begin dec.ctrl = 11'h209; ill = f3 != 3'd0; end
            7'h63: begin
                dec.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                dec.ctrl = 11'h002;
                dec.brop = f3;
                ill = f3[2:1] == 2'b01;
            end
            7'h03: begin
                dec.ctrl = 11'h111 | {4'b0, f3[2], 6'b0};
                dec.dwidth = f3[1:0];
                ill = f3[1:0] == 2'b11 || f3[2:1] == 2'b11;
            end
            7'h23: begin
                dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                dec.ctrl = 11'h120;
                ill = f3 > 3'd2;
            end
            7'h13: begin
                dec.ctrl = 11'h101;
                dec.aluop = f3 == 3'd5 && f7 == 7'h20 ? 4'd7 : alu_of(f3);
                ill = f3 == 3'd1 ? f7 != 7'h00 : f3 == 3'd5 ? f7 != 7'h00 && f7 != 7'h20 : 1'b0;
            end
            7'h33: begin
                dec.ctrl = f7 == 7'h01 && EN_M ? 11'h401 : 11'h001;
                dec.mdop = f7 == 7'h01 ? f3 : 3'd0;
                dec.aluop = f7 == 7'h20 ? (f3 == 3'd0 ? 4'd1 : 4'd7) : f7 == 7'h00 ? alu_of(f3) : 4'd0;
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && EN_M));
            end
            7'h0f: ;
            default: ill = 1'b1;
        endcase
        ill = ill | (inst[1:0] != 2'b11);
        if (ill) begin
            dec.aluop = '0;
            dec.brop = '0;
            dec.mdop = '0;
            dec.dwidth = '0;
            dec.ctrl = '0;
        end
        if (inst[11:7] == 5'd0) dec.ctrl[0] = 1'b0;
        dec.illegal = ill;
    end
    assign bus.in_ready = (cnt != CW'(DEPTH)) & rst_n;
    assign bus.out_valid = cnt != '0;
    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop = bus.out_valid & bus.out_ready & ~bus.flush;
    always_ff @(posedge clk)
        if (push) mem[wp] <= dec;
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            cnt <= '0;
            rp <= '0;
            wp <= '0;
        end else begin
            if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    assign head = bus.out_valid ? mem[rp] : '0;
    assign bus.out_pc = head.pc;
    assign bus.out_inst = head.inst;
    assign bus.out_rd = head.inst[11:7];
    assign bus.out_rs1 = head.inst[19:15];
    assign bus.out_rs2 = head.inst[24:20];
    assign bus.out_imm = head.imm;
    assign bus.out_aluop = head.aluop;
    assign bus.out_brop = head.brop;
    assign bus.out_mdop = head.mdop;
    assign bus.out_dwidth = head.dwidth;
    assign bus.out_ctrl = head.ctrl;
    assign bus.out_illegal = head.illegal;
endmodule

// File: tb/tb_rvga_decode_pipe.sv
// tb_rvga_decode_pipe: two decode pipes (EN_M=0 and EN_M=1) driven alike and compared to a queue-based reference
module tb_rvga_decode_pipe;
    localparam int D = 2;
    logic clk = 1'b0, rst_n = 1'b0;
    logic v = 1'b0, fl = 1'b0, ordy = 1'b0;
    logic [31:0] pc = '0, ins = '0;
    int checks = 0, failures = 0;
    typedef struct packed {logic [31:0] pc; logic [31:0] inst;} item_t;
    typedef struct packed {
        logic [31:0] imm; logic [3:0] alu; logic [2:0] br; logic [2:0] md;
        logic [1:0] dw; logic [10:0] ctrl; logic ill;
    } exp_t;
    item_t q[$];
    rvga_decode_pipe_if b0 ();
    rvga_decode_pipe_if b1 ();
    assign b0.flush = fl;
    assign b0.in_valid = v;
    assign b0.in_pc = pc;
    assign b0.in_inst = ins;
    assign b0.out_ready = ordy;
    assign b1.flush = fl;
    assign b1.in_valid = v;
    assign b1.in_pc = pc;
    assign b1.in_inst = ins;
    assign b1.out_ready = ordy;
    rvga_decode_pipe #(.XLEN(32), .DEPTH(D), .EN_M(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    rvga_decode_pipe #(.XLEN(32), .DEPTH(D), .EN_M(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    always #5 clk = ~clk;
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    // Reference decode straight from the instruction-set rules, one opcode class at a time
    function automatic exp_t ref_dec(logic [31:0] i, bit m);
        int amap [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        exp_t e = '0;
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        bit ok = 1;
        e.imm = 32'($signed(i[31:20]));
        if (i[1:0] != 2'b11) ok = 0;
        else case (i[6:0])
            7'h37: begin e.ctrl = 11'h101; e.alu = 10; e.imm = {i[31:12], 12'h000}; end
            7'h17: begin e.ctrl = 11'h181; e.imm = {i[31:12], 12'h000}; end
            7'h6f: begin e.ctrl = 11'h285; e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h67: begin e.ctrl = 11'h209; ok = f3 == 0; end
            7'h63: begin
                e.ctrl = 11'h002; e.br = f3; ok = !(f3 inside {2, 3});
                e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h03: begin
                e.ctrl = f3[2] ? 11'h151 : 11'h111; e.dw = f3[1:0]; ok = f3 inside {0, 1, 2, 4, 5};
            end
            7'h23: begin e.ctrl = 11'h120; ok = f3 <= 2; e.imm = 32'($signed({i[31:25], i[11:7]})); end
            7'h13: begin
                e.ctrl = 11'h101; e.alu = 4'(amap[f3]);
                if (f3 == 1) ok = f7 == 0;
                if (f3 == 5) begin ok = f7 inside {7'h00, 7'h20}; if (f7 == 7'h20) e.alu = 7; end
            end
            7'h33: begin
                e.ctrl = 11'h001;
                if (f7 == 7'h00) e.alu = 4'(amap[f3]);
                else if (f7 == 7'h20) begin ok = f3 inside {0, 5}; e.alu = f3 == 0 ? 1 : 7; end
                else if (f7 == 7'h01 && m) begin e.ctrl = 11'h401; e.md = f3; end
                else ok = 0;
            end
            7'h0f: ;
            default: ok = 0;
        endcase
        if (!ok) begin e = '0; e.imm = (i[1:0] == 2'b11 && i[6:0] inside {7'h67, 7'h13, 7'h33, 7'h03}) ? 32'($signed(i[31:20])) : e.imm; end
        if (!ok) begin
            case (i[6:0])
                7'h37, 7'h17: e.imm = {i[31:12], 12'h000};
                7'h6f: e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
                7'h63: e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
                7'h23: e.imm = 32'($signed({i[31:25], i[11:7]}));
                default: e.imm = 32'($signed(i[31:20]));
            endcase
            e.ill = 1;
        end
        if (i[11:7] == 0) e.ctrl[0] = 0;
        return e;
    endfunction
    task automatic check_dut(string n, bit m, logic ov, logic ir, logic [31:0] opc, logic [31:0] oins,
                             logic [31:0] oimm, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                             logic [3:0] al, logic [2:0] br, logic [2:0] md, logic [1:0] dw,
                             logic [10:0] ct, logic il);
        bit has = q.size() != 0;
        item_t h = has ? q[0] : '0;
        exp_t e = has ? ref_dec(h.inst, m) : '0;
        chk({n, ".in_ready"}, 32'(ir), 32'(rst_n && q.size() < D));
        chk({n, ".out_valid"}, 32'(ov), 32'(has));
        chk({n, ".out_pc"}, opc, h.pc);
        chk({n, ".out_inst"}, oins, h.inst);
        chk({n, ".regs"}, {17'b0, rd, rs1, rs2}, {17'b0, h.inst[11:7], h.inst[19:15], h.inst[24:20]});
        chk({n, ".out_imm"}, oimm, e.imm);
        chk({n, ".ops"}, {20'b0, al, br, md, dw}, {20'b0, e.alu, e.br, e.md, e.dw});
        chk({n, ".out_ctrl"}, 32'(ct), 32'(e.ctrl));
        chk({n, ".out_illegal"}, 32'(il), 32'(e.ill));
    endtask
    task automatic cyc(logic nv, logic [31:0] npc, logic [31:0] ni, logic nr, logic nf = 1'b0, logic nrst = 1'b1);
        bit push, pop;
        @(negedge clk);
        v = nv; pc = npc; ins = ni; ordy = nr; fl = nf; rst_n = nrst;
        #1;
        check_dut("m0", 0, b0.out_valid, b0.in_ready, b0.out_pc, b0.out_inst, b0.out_imm, b0.out_rd, b0.out_rs1,
                  b0.out_rs2, b0.out_aluop, b0.out_brop, b0.out_mdop, b0.out_dwidth, b0.out_ctrl, b0.out_illegal);
        check_dut("m1", 1, b1.out_valid, b1.in_ready, b1.out_pc, b1.out_inst, b1.out_imm, b1.out_rd, b1.out_rs1,
                  b1.out_rs2, b1.out_aluop, b1.out_brop, b1.out_mdop, b1.out_dwidth, b1.out_ctrl, b1.out_illegal);
        push = v && rst_n && !fl && q.size() < D;
        pop = q.size() != 0 && ordy && !fl;
        @(posedge clk);
        if (!rst_n || fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({pc, ins});
        end
        #1;
    endtask
    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        logic [31:0] i = $urandom;
        int k = $urandom_range(0, 11);
        if (k < 11) i[6:0] = ops[k];
        if (i[6:0] inside {7'h13, 7'h33})
            case ($urandom_range(0, 3))
                0: i[31:25] = 7'h00;
                1: i[31:25] = 7'h20;
                2: i[31:25] = 7'h01;
                default: ;
            endcase
        return i;
    endfunction
    localparam logic [31:0] ADDI = 32'hFFF10093, BEQ = 32'hFE000EE3, NOP = 32'h00000013;
    localparam logic [31:0] MUL = 32'h022081B3, ECALL = 32'h00000073;
    initial begin
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst.out_valid", 32'(b0.out_valid), 0);
        chk("rst.in_ready", 32'(b0.in_ready), 0);
        cyc(0, 0, 0, 1);
        chk("rel.in_ready", 32'(b0.in_ready), 1);
        cyc(1, 32'h100, ADDI, 1);
        chk("addi.valid", 32'(b0.out_valid), 1);
        chk("addi.imm", b0.out_imm, 32'hFFFFFFFF);
        chk("addi.ctrl", 32'(b0.out_ctrl), 32'h101);
        chk("addi.rd_rs1", {b0.out_rd, b0.out_rs1}, {5'd1, 5'd2});
        chk("addi.pc", b0.out_pc, 32'h100);
        cyc(1, 32'h104, BEQ, 1);
        chk("beq.imm", b0.out_imm, 32'hFFFFFFFC);
        chk("beq.ctrl", 32'(b0.out_ctrl), 32'h002);
        cyc(1, 32'h108, NOP, 1);
        chk("nop.ctrl", 32'(b0.out_ctrl), 32'h100);
        cyc(0, 0, 0, 1);
        chk("drain.valid", 32'(b0.out_valid), 0);
        chk("drain.pc", b0.out_pc, 0);
        cyc(1, 32'h200, MUL, 0);
        chk("mul0.illegal", 32'(b0.out_illegal), 1);
        chk("mul0.ctrl", 32'(b0.out_ctrl), 0);
        chk("mul1.ctrl", 32'(b1.out_ctrl), 32'h401);
        chk("mul1.illegal", 32'(b1.out_illegal), 0);
        cyc(1, 32'h204, ECALL, 0);
        chk("full.in_ready", 32'(b0.in_ready), 0);
        cyc(1, 32'h208, ADDI, 0);
        cyc(0, 0, 0, 1);
        chk("pop1.pc", b0.out_pc, 32'h204);
        chk("ecall.illegal", 32'(b1.out_illegal), 1);
        chk("pop1.in_ready", 32'(b0.in_ready), 1);
        cyc(0, 0, 0, 1);
        chk("pop2.valid", 32'(b0.out_valid), 0);
        cyc(1, 32'h300, ADDI, 0);
        cyc(1, 32'h304, ADDI, 0);
        cyc(1, 32'h308, BEQ, 0, 1);
        chk("flush.valid", 32'(b0.out_valid), 0);
        cyc(0, 0, 0, 1);
        chk("flush.dropped", 32'(b0.out_valid), 0);
        cyc(1, 32'h400, ADDI, 0);
        cyc(1, 32'h404, ADDI, 1, 0, 0);
        chk("rst2.valid", 32'(b0.out_valid), 0);
        chk("rst2.inst", b0.out_inst, 0);
        chk("rst2.in_ready", 32'(b0.in_ready), 0);
        cyc(0, 0, 0, 0);
        chk("rst2.rel_ready", 32'(b0.in_ready), 1);
        chk("rst2.rel_valid", 32'(b0.out_valid), 0);
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(0, 3) != 0, $urandom, rand_inst(), $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rvga_decode_pipe.md
Name: rvga_decode_pipe

Overview:
Next-generation RV32I decode stage for the rvga pipeline, between fetch and register-file read.
- Replaces the stall-driven decode register with a valid/ready handshake and a parametrised output FIFO of pre-decoded entries.
- Adds correct sign-extended immediates, illegal-instruction detection, an optional M-extension decode path and a synchronous pipeline flush.

Parameters:
XLEN, 32, datapath and immediate width; only 32 is supported.
DEPTH, 2, number of decoded entries buffered; legal range 1..8.
EN_M, 0, 1 = decode the RV32M MUL/DIV group; 0 = flag those encodings illegal.

Ports:
clk  in  1  clock
rst_n  in  1  reset
flush  in  1  discard all buffered entries and any input presented this cycle
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode can accept the instruction
in_pc  in  XLEN  PC of the instruction
in_inst  in  32  raw instruction
out_valid  out  1  head entry valid
out_ready  in  1  register-file stage consumes head
out_pc  out  XLEN  head PC
out_inst  out  32  head raw instruction
out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], [19:15], [24:20]
out_imm  out  XLEN  sign-extended immediate
out_aluop  out  4  add0 sub1 sll2 slt3 sltu4 xor5 srl6 sra7 or8 and9 passb10
out_brop  out  3  beq0 bne1 blt4 bge5 bltu6 bgeu7 (equal to funct3)
out_mdop  out  3  funct3 of an M-op
out_dwidth  out  2  byte0 half1 word2
out_ctrl  out  11  [0]rf_load [1]br_en [2]jal_en [3]jalr_en [4]mem_read [5]mem_write [6]mem_unsigned [7]rs1_pc [8]rs2_imm [9]rs2_wordsize [10]md_en
out_illegal  out  1  head entry is an illegal instruction

Behaviour:
- Reset and clocking: rst_n is synchronous, active-low; clock is clk. While rst_n is low, count, read pointer and write pointer clear to 0; no push occurs.
- Output masking: every out_* field is 0 whenever out_valid=0, including during and after reset.
- Decode path: decode is combinational on in_inst. The decoded entry plus pc/inst is written to the FIFO on push = in_valid & in_ready & ~flush.
- Handshake:
  - in_ready = (count != DEPTH) & rst_n. It never depends combinationally on out_ready, so a full FIFO does not accept input in a cycle where it pops.
  - pop = out_valid & out_ready & ~flush.
  - out_valid = (count != 0).
- Latency: an instruction accepted in cycle N with the FIFO empty is visible at the outputs in cycle N+1. Order is strictly FIFO.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, both pointers advance, and pointers wrap modulo DEPTH.
- Flush: count and pointers clear at the next edge and out_valid=0 in the following cycle. The input in the flush cycle is dropped, and flush overrides push and pop.
- Immediate formats:
  - I-type: sext(inst[31:20]).
  - S-type: sext({inst[31:25], inst[11:7]}).
  - B-type: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U-type: {inst[31:12], 12'b0}.
  - J-type: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- Control per opcode:
  - LUI: passb, rs2_imm, rf_load.
  - AUIPC: add, rs1_pc, rs2_imm, rf_load.
  - JAL: add, rs1_pc, rs2_wordsize, jal_en, rf_load.
  - JALR: add, rs2_wordsize, jalr_en, rf_load. funct3 must be 0.
  - BRANCH: br_en, brop=funct3. funct3 of 2 or 3 is illegal.
  - LOAD: mem_read, rf_load, aluop add, rs2_imm. dwidth comes from funct3[1:0]; mem_unsigned = funct3[2]. funct3 of 3, 6 or 7 is illegal.
  - STORE: mem_write, aluop add, rs2_imm. funct3 must be 0..2.
  - OP-IMM: rs2_imm, rf_load. For SLLI, funct7 must be 0. For SRLI/SRAI, funct7 must be 0x00 or 0x20.
  - OP: rf_load.
    - funct7=0x20 is legal only with funct3 0 or 5 (sub, sra).
    - funct7=0x01 with EN_M=1 gives md_en=1, mdop=funct3, rf_load=1; with EN_M=0 it is illegal.
    - Any other funct7 is illegal.
  - MISC-MEM (FENCE): legal no-op with all ctrl bits 0.
  - SYSTEM: illegal (the trap is taken downstream).
  - Any other opcode, or inst[1:0] != 2'b11: illegal.
- Illegal entries: out_illegal=1, with ctrl, aluop, brop, mdop and dwidth all 0. pc, inst, register fields and imm still pass through.
- rd = x0: rf_load is forced to 0 for all opcodes.

Test Plan:
- Push ADDI x1,x2,-1 (0xFFF10093), pc 0x100, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, aluop=0, ctrl=0x101, rd=1, rs1=2, out_pc=0x100.
- Push BEQ x0,x0,-4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, brop=0, ctrl=0x002; push 0x00000013 (addi x0,x0,0) -> ctrl=0x100 (rf_load suppressed).
- DEPTH=2, out_ready=0, offer three instructions back-to-back -> in_ready falls after the 2nd accept and the 3rd is held. Then out_ready=1 -> entries pop in order one per cycle, and in_ready returns one cycle after the first pop.
- MUL x3,x1,x2 (0x022081B3): with EN_M=0 -> out_illegal=1, ctrl=0; with EN_M=1 -> ctrl=0x401, mdop=0. ECALL (0x00000073) -> out_illegal=1.
- Fill FIFO with 2 entries, assert flush together with in_valid=1 -> next cycle out_valid=0, count=0, and the flushed-cycle input is absent afterwards.
- Assert rst_n=0 for one cycle with 1 entry buffered and in_valid=1 -> out_valid=0, all outputs 0, in_ready=0 during reset and 1 the cycle after release.
